uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter path (reference-clock side, ahead of the transmitter data synchronizer) between REQUESTER_COUNT response sources, e.g. register-file read data, ALU result and status reporter.
- Arbitrates round-robin and serialises each 1- or 2-byte response into single-byte transmit requests.
- Paces each byte off the synchronized transmitter busy flag.
- Aborts a byte with an error pulse when the transmitter never acknowledges it.

---
 rtl/uart_tx_scheduler_pkg.sv | 21 ++
 rtl/uart_tx_scheduler_round_robin_arbiter.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states and the
// byte index within a latched 1- or 2-byte response frame.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_e;

  typedef enum logic {
    BYTE_LOW  = 1'b0,
    BYTE_HIGH = 1'b1
  } byte_idx_e;

  // Width of an index into n entries; never zero so a 1-entry case still has a bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_round_robin_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping past the top requester. The pointer register lives in the parent.
module uart_tx_scheduler_round_robin_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int REQUESTER_COUNT = 3,
  parameter int PW              = index_width(REQUESTER_COUNT)
) (
  input  logic [REQUESTER_COUNT-1:0] request,
  input  logic [PW-1:0]              pointer,
  output logic [REQUESTER_COUNT-1:0] winner_onehot,
  output logic [PW-1:0]              winner_index,
  output logic                       any_request
);

  logic found_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int cand;
    found_s       = 1'b0;
    winner_onehot = {REQUESTER_COUNT{1'b0}};
    winner_index  = {PW{1'b0}};
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      cand = (int'(pointer) + k) % REQUESTER_COUNT;
      if (!found_s && request[PW'(cand)]) begin
        found_s                     = 1'b1;
        winner_onehot[PW'(cand)]    = 1'b1;
        winner_index                = PW'(cand);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_request = |request;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between several response sources: round-robin
// grant, byte-by-byte serialisation paced by the synchronized busy flag.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REQUESTER_COUNT     = 3,
  parameter int BUSY_TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [REQUESTER_COUNT-1:0]             request,
  input  logic [REQUESTER_COUNT*2*DATA_WIDTH-1:0] request_data,
  input  logic [REQUESTER_COUNT-1:0]             request_two_bytes,
  output logic [REQUESTER_COUNT-1:0]             grant,
  input  logic                                   transmitter_busy_synchronized,
  output logic                                   transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]                  transmitter_parallel_data,
  output logic                                   scheduler_busy,
  output logic                                   timeout_error
);

  localparam int PW = index_width(REQUESTER_COUNT);
  localparam int TW = index_width(BUSY_TIMEOUT_CYCLES);
  localparam int FW = 2 * DATA_WIDTH;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [PW-1:0] LAST_REQ   = PW'(REQUESTER_COUNT - 1);

  sched_state_e                 state_r, state_s;
  byte_idx_e                    byte_r, byte_s;
  logic [PW-1:0]                ptr_r, ptr_s;
  logic [PW-1:0]                idx_r, idx_s;
  logic                         two_r, two_s;
  logic [FW-1:0]                frame_r, frame_s;
  logic [TW-1:0]                timer_r, timer_s;
  logic [REQUESTER_COUNT-1:0]   grant_r, grant_s;
  logic                         valid_r, valid_s;
  logic [DATA_WIDTH-1:0]        data_r, data_s;
  logic                         sbusy_r, sbusy_s;
  logic                         terr_r, terr_s;

  logic [REQUESTER_COUNT-1:0]         win_onehot_s;
  logic [PW-1:0]                      win_idx_s;
  logic                               any_req_s;
  logic [PW-1:0]                      next_ptr_s;
  logic [REQUESTER_COUNT-1:0][FW-1:0] frames_s;

  assign frames_s   = request_data;
  assign next_ptr_s = (idx_r == LAST_REQ) ? {PW{1'b0}} : idx_r + PW'(1);

  uart_tx_scheduler_round_robin_arbiter #(
    .REQUESTER_COUNT (REQUESTER_COUNT),
    .PW              (PW)
  ) u_arbiter (
    .request       (request),
    .pointer       (ptr_r),
    .winner_onehot (win_onehot_s),
    .winner_index  (win_idx_s),
    .any_request   (any_req_s)
  );

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_s = state_r;
    byte_s  = byte_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    two_s   = two_r;
    frame_s = frame_r;
    timer_s = timer_r;
    grant_s = {REQUESTER_COUNT{1'b0}};
    valid_s = valid_r;
    data_s  = data_r;
    terr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A busy transmitter could still be finishing someone else's frame.
        if (any_req_s && !transmitter_busy_synchronized) begin
          grant_s = win_onehot_s;
          idx_s   = win_idx_s;
          frame_s = frames_s[win_idx_s];
          two_s   = request_two_bytes[win_idx_s];
          byte_s  = BYTE_LOW;
          data_s  = frames_s[win_idx_s][DATA_WIDTH-1:0];
          valid_s = 1'b1;
          timer_s = {TW{1'b0}};
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (transmitter_busy_synchronized) begin
          valid_s = 1'b0;
          state_s = ST_WAIT_DONE;
        end else if (timer_r == TIMER_LAST) begin
          valid_s = 1'b0;
          terr_s  = 1'b1;
          ptr_s   = next_ptr_s;
          state_s = ST_IDLE;
        end else begin
          timer_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!transmitter_busy_synchronized) begin
          if (two_r && (byte_r == BYTE_LOW)) begin
            byte_s  = BYTE_HIGH;
            data_s  = frame_r[FW-1:DATA_WIDTH];
            valid_s = 1'b1;
            timer_s = {TW{1'b0}};
            state_s = ST_SEND;
          end else begin
            ptr_s   = next_ptr_s;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
    sbusy_s = (state_s != ST_IDLE);
  end

  // State, frame and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      byte_r  <= BYTE_LOW;
      ptr_r   <= {PW{1'b0}};
      idx_r   <= {PW{1'b0}};
      two_r   <= 1'b0;
      frame_r <= {FW{1'b0}};
      timer_r <= {TW{1'b0}};
      grant_r <= {REQUESTER_COUNT{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
      sbusy_r <= 1'b0;
      terr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      byte_r  <= byte_s;
      ptr_r   <= ptr_s;
      idx_r   <= idx_s;
      two_r   <= two_s;
      frame_r <= frame_s;
      timer_r <= timer_s;
      grant_r <= grant_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      sbusy_r <= sbusy_s;
      terr_r  <= terr_s;
    end
  end

  assign grant                           = grant_r;
  assign transmitter_parallel_data_valid = valid_r;
  assign transmitter_parallel_data       = data_r;
  assign scheduler_busy                  = sbusy_r;
  assign timeout_error                   = terr_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed plus randomized bench for uart_tx_scheduler; the bench plays both
// the requesters and the transmitter, predicting grants and bytes from a small model.
module tb_uart_tx_scheduler;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  request = 3'b000;
  logic [47:0]   request_data = 48'h0;
  logic [N-1:0]  request_two_bytes = 3'b000;
  logic [N-1:0]  grant;
  logic          busy = 1'b0;
  logic          valid;
  logic [DW-1:0] data;
  logic          sbusy;
  logic          terr;

  int            n_cmp = 0;
  int            n_err = 0;
  int            ptr_m = 0;
  logic [15:0]   frame_m [N];
  bit            two_m [N];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_WIDTH          (DW),
    .REQUESTER_COUNT     (N),
    .BUSY_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                             (clk),
    .reset                           (reset),
    .request                         (request),
    .request_data                    (request_data),
    .request_two_bytes               (request_two_bytes),
    .grant                           (grant),
    .transmitter_busy_synchronized   (busy),
    .transmitter_parallel_data_valid (valid),
    .transmitter_parallel_data       (data),
    .scheduler_busy                  (sbusy),
    .timeout_error                   (terr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester counting up from the pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic raise(input int i, input logic [15:0] d, input bit two);
    request[i]               = 1'b1;
    request_data[i*16 +: 16] = d;
    request_two_bytes[i]     = two;
    frame_m[i]               = d;
    two_m[i]                 = two;
  endtask

  // Transmitter side for one byte: accept after delay cycles, stay busy for hold cycles.
  task automatic serve_byte(input string tag, input logic [7:0] exp_b, input int delay, input int hold);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, 32'(data), 32'(exp_b));
    repeat (delay) tick();
    chk({tag, "_valid_held"}, 32'(valid), 32'd1);
    busy = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
    chk({tag, "_data_hold"}, 32'(data), 32'(exp_b));
    chk({tag, "_sbusy_wait"}, 32'(sbusy), 32'd1);
    repeat (hold - 1) tick();
    busy = 1'b0;
    tick();
  endtask

  task automatic run_frame(input string tag, input bit keep, input int delay, input int hold);
    int w;
    w = pick(request, ptr_m);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'd1 << w);
    chk({tag, "_sbusy"}, 32'(sbusy), 32'd1);
    chk({tag, "_terr_idle"}, 32'(terr), 32'd0);
    if (!keep) request[w] = 1'b0;
    serve_byte({tag, "_lo"}, frame_m[w][7:0], delay, hold);
    if (two_m[w]) serve_byte({tag, "_hi"}, frame_m[w][15:8], delay, hold);
    chk({tag, "_end_valid"}, 32'(valid), 32'd0);
    chk({tag, "_end_sbusy"}, 32'(sbusy), 32'd0);
    chk({tag, "_end_grant"}, 32'(grant), 32'd0);
    ptr_m = (w + 1) % N;
  endtask

  // Transmitter never answers: valid must stay up exactly TO cycles, then one error pulse.
  task automatic run_timeout(input string tag);
    int w;
    int cnt;
    w = pick(request, ptr_m);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'd1 << w);
    request[w] = 1'b0;
    cnt = 1;
    for (int i = 0; i < 3 * TO; i++) begin
      tick();
      if (valid !== 1'b1) break;
      cnt++;
    end
    chk({tag, "_valid_cycles"}, 32'(cnt), 32'(TO));
    chk({tag, "_terr"}, 32'(terr), 32'd1);
    chk({tag, "_sbusy"}, 32'(sbusy), 32'd0);
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_sbusy", 32'(sbusy), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_sbusy", 32'(sbusy), 32'd0);

    raise(0, 16'h00A5, 1'b0);
    run_frame("single", 1'b0, 5, 3);
    raise(1, 16'h12F0, 1'b1);
    run_frame("two_byte", 1'b0, 2, 4);

    busy = 1'b1;
    raise(2, 16'h0033, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_first_nogrant", 32'(grant), 32'd0);
    end
    busy = 1'b0;
    run_frame("busy_first", 1'b0, 1, 2);

    for (int i = 0; i < N; i++) raise(i, 16'($urandom), 1'($urandom_range(0, 1)));
    for (int f = 0; f < 4; f++) run_frame("rr", 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    request = 3'b000;

    raise(1, 16'hBEEF, 1'b1);
    tick();
    chk("rstmid_grant", 32'(grant), 32'd2);
    request[1] = 1'b0;
    tick();
    busy = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_grant0", 32'(grant), 32'd0);
    chk("rstmid_valid0", 32'(valid), 32'd0);
    chk("rstmid_data0", 32'(data), 32'd0);
    chk("rstmid_sbusy0", 32'(sbusy), 32'd0);
    chk("rstmid_terr0", 32'(terr), 32'd0);
    busy = 1'b0;
    ptr_m = 0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_replay", 32'(valid), 32'd0);
    end
    for (int i = 0; i < N; i++) raise(i, 16'($urandom), 1'b0);
    run_frame("after_reset", 1'b0, 1, 1);
    request = 3'b000;

    raise(0, 16'h5A3C, 1'b1);
    run_timeout("timeout");
    for (int i = 0; i < N; i++) raise(i, 16'($urandom), 1'($urandom_range(0, 1)));
    run_frame("after_timeout", 1'b0, 1, 1);
    request = 3'b000;

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!request[i] && ($urandom_range(0, 1) == 1)) raise(i, 16'($urandom), 1'($urandom_range(0, 1)));
      end
      if (request == 3'b000) raise(int'($urandom_range(0, N - 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) run_timeout("rnd_timeout");
      else run_frame("rnd", 1'b0, int'($urandom_range(0, 6)), int'($urandom_range(1, 4)));
    end
    request = 3'b000;
    tick();
    chk("final_terr", 32'(terr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
